// File: rtl/ps2_key_event_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_fifo_if
//  Description : Bundle between the PS/2 byte receiver / processor side and
//                the key-event FIFO.
//                  ps2_key_pressed / ps2_key_data : raw scan-code byte strobe
//                  evt_pop / clear_overflow       : consumer controls
//                  evt_valid / evt_code / evt_extended / evt_release
//                                                 : FWFT head entry
//                  evt_count                      : occupied entries
//                  overflow                       : sticky event-lost flag
//                master drives bytes and consumer controls; slave is the FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_key_event_fifo_if #(
  parameter int ADDR_W = 3
);
  logic              ps2_key_pressed;
  logic [7:0]        ps2_key_data;
  logic              evt_pop;
  logic              clear_overflow;
  logic              evt_valid;
  logic [7:0]        evt_code;
  logic              evt_extended;
  logic              evt_release;
  logic [ADDR_W:0]   evt_count;
  logic              overflow;

  modport master (
    output ps2_key_pressed, ps2_key_data, evt_pop, clear_overflow,
    input  evt_valid, evt_code, evt_extended, evt_release, evt_count, overflow
  );

  modport slave (
    input  ps2_key_pressed, ps2_key_data, evt_pop, clear_overflow,
    output evt_valid, evt_code, evt_extended, evt_release, evt_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_fifo
//  Description : Parses PS/2 set-2 scan-code bytes (E0 extended prefix, F0
//                break prefix) into {extended, release, code} key events,
//                optionally drops typematic repeats of the held key, and
//                buffers events in a first-word-fall-through FIFO.
//  Ports       : clock  - system clock
//                resetn - asynchronous active-low reset
//                bus    - ps2_key_event_fifo_if.slave (byte strobe in,
//                         pop / clear_overflow in, FWFT head, count, overflow)
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_event_fifo #(
  parameter int DEPTH           = 8,
  parameter int ADDR_W          = 3,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  wire logic            clock,
  input  wire logic            resetn,
  ps2_key_event_fifo_if.slave  bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_e0   = 2'd1;
  localparam logic [1:0] c_st_f0   = 2'd2;
  localparam logic [1:0] c_st_e0f0 = 2'd3;

  localparam logic [7:0] c_byte_e0 = 8'hE0;
  localparam logic [7:0] c_byte_f0 = 8'hF0;
  localparam logic [7:0] c_byte_00 = 8'h00;
  localparam logic [7:0] c_byte_ff = 8'hFF;

  localparam logic [ADDR_W:0] c_full = (ADDR_W+1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Byte classification
  // --------------------------------------------------------------------------
  logic [7:0] byte_w;
  logic       is_e0, is_f0, is_err;

  assign byte_w = bus.ps2_key_data;
  assign is_e0  = (byte_w == c_byte_e0);
  assign is_f0  = (byte_w == c_byte_f0);
  assign is_err = (byte_w == c_byte_00) || (byte_w == c_byte_ff);

  // --------------------------------------------------------------------------
  // Parser FSM: state register
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= c_st_idle;
    else         state_q <= state_d;
  end

  // Parser FSM: next state (advances only on a byte strobe)
  always_comb begin
    state_d = state_q;
    if (bus.ps2_key_pressed) begin
      case (state_q)
        c_st_idle: begin
          if (is_e0)      state_d = c_st_e0;
          else if (is_f0) state_d = c_st_f0;
          else            state_d = c_st_idle;
        end
        c_st_e0: begin
          if (is_f0)      state_d = c_st_e0f0;
          else if (is_e0) state_d = c_st_e0;
          else            state_d = c_st_idle;
        end
        c_st_f0: begin
          // E0 after F0 restarts the prefix; the stale F0 is forgotten.
          if (is_f0)      state_d = c_st_f0;
          else if (is_e0) state_d = c_st_e0;
          else            state_d = c_st_idle;
        end
        default: begin
          if (is_e0 || is_f0) state_d = c_st_e0f0;
          else                state_d = c_st_idle;
        end
      endcase
    end
  end

  // Parser FSM: outputs. Any non-prefix, non-error byte completes an event;
  // the prefixes seen so far (encoded in the state) give ext/rel.
  logic parse_valid, parse_ext, parse_rel;

  always_comb begin
    parse_valid = 1'b0;
    parse_ext   = 1'b0;
    parse_rel   = 1'b0;
    if (bus.ps2_key_pressed && !is_e0 && !is_f0 && !is_err) begin
      parse_valid = 1'b1;
      parse_ext   = (state_q == c_st_e0) || (state_q == c_st_e0f0);
      parse_rel   = (state_q == c_st_f0) || (state_q == c_st_e0f0);
    end
  end

  // --------------------------------------------------------------------------
  // Held-key tracker
  // --------------------------------------------------------------------------
  logic       held_valid_q, held_valid_d;
  logic       held_ext_q,   held_ext_d;
  logic [7:0] held_code_q,  held_code_d;
  logic       held_match;
  logic       repeat_drop;

  assign held_match = held_valid_q && (held_ext_q == parse_ext) &&
                      (held_code_q == byte_w);

  generate
    if (SUPPRESS_REPEAT != 0) begin : g_suppress
      assign repeat_drop = parse_valid && !parse_rel && held_match;
    end else begin : g_no_suppress
      assign repeat_drop = 1'b0;
    end
  endgenerate

  // The tracker follows every parsed event, even ones lost to a full FIFO,
  // so it always mirrors the physical keyboard state.
  always_comb begin
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    if (parse_valid && !parse_rel) begin
      held_valid_d = 1'b1;
      held_ext_d   = parse_ext;
      held_code_d  = byte_w;
    end else if (parse_valid && parse_rel && held_match) begin
      held_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
    end else begin
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              overflow_q, overflow_d;
  logic [9:0]        mem_q [DEPTH];
  logic [9:0]        mem_d [DEPTH];
  logic              push_req, push_en, pop_en, full, empty;
  logic [9:0]        head;

  assign push_req = parse_valid && !repeat_drop;
  assign full     = (count_q == c_full);
  assign empty    = (count_q == '0);
  assign pop_en   = bus.evt_pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_en  = push_req && (!full || pop_en);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q && !bus.clear_overflow;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    if (push_en) begin
      mem_d[wr_ptr_q] = {parse_ext, parse_rel, byte_w};
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Set takes priority over a simultaneous clear.
    if (push_req && !push_en) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.evt_valid    = !empty;
  assign bus.evt_extended = !empty && head[9];
  assign bus.evt_release  = !empty && head[8];
  assign bus.evt_code     = empty ? 8'h00 : head[7:0];
  assign bus.evt_count    = count_q;
  assign bus.overflow     = overflow_q;

endmodule
`default_nettype wire
